// File: rtl/clk_phase_ctrl.sv
// Start/stop sequencer and phase tracker deriving clk4f/clk2f/clkf from clk16f.
// Latency: outputs registered; RUN reached SETTLE_CYC cycles after run_req is sampled high.
// Backpressure: none; run_req is a level request, stops complete at the next clkf frame boundary.
module clk_phase_ctrl #(
  parameter int unsigned SETTLE_CYC = 8  // legal range 1..15
) (
  input  logic       clk16f,
  input  logic       reset_L,
  input  logic       run_req,
  output logic       clk4f,
  output logic       clk2f,
  output logic       clkf,
  output logic [3:0] phase,
  output logic       frame_strb,
  output logic       clk_ready
);

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_SETTLE   = 2'b01;
  localparam logic [1:0] ST_RUN      = 2'b10;
  localparam logic [1:0] ST_STOPPING = 2'b11;

  // Counter is loaded with one less than the settle length because the
  // cycle in which it reaches zero still belongs to SETTLE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] PHASE_LAST  = 4'hF;

  logic [1:0] state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [3:0] settle_q, settle_d;
  logic       clk4f_q, clk4f_d;
  logic       clk2f_q, clk2f_d;
  logic       clkf_q, clkf_d;
  logic       frame_strb_q, frame_strb_d;
  logic       clk_ready_q, clk_ready_d;

  // Sequencer next state: phase only advances in RUN/STOPPING, and the only
  // way back to IDLE from a running clock is through the end of phase 15.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    settle_d = settle_q;
    unique case (state_q)
      ST_IDLE: begin
        phase_d = 4'd0;
        if (run_req) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        phase_d = 4'd0;
        if (!run_req) begin
          // Abandoned settle is not resumed; the next request reloads it.
          state_d = ST_IDLE;
        end else if (settle_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_RUN: begin
        phase_d = phase_q + 4'd1;
        if (!run_req) begin
          if (phase_q == PHASE_LAST) begin
            state_d = ST_IDLE;
            phase_d = 4'd0;
          end else begin
            state_d = ST_STOPPING;
          end
        end
      end
      ST_STOPPING: begin
        // Keep toggling so the final clkf low half-period is never cut short.
        phase_d = phase_q + 4'd1;
        if (run_req) begin
          state_d = ST_RUN;
        end else if (phase_q == PHASE_LAST) begin
          state_d = ST_IDLE;
          phase_d = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 4'd0;
      end
    endcase
  end

  // Output decode from next-state values so every output is a flop and
  // lines up with the phase it describes.
  always_comb begin
    clk4f_d      = ~phase_d[1];
    clk2f_d      = ~phase_d[2];
    clkf_d       = ~phase_d[3];
    frame_strb_d = (state_d == ST_RUN) && (phase_d == PHASE_LAST);
    clk_ready_d  = (state_d == ST_RUN);
  end

  // State and output registers; reset parks all clocks high at phase 0.
  always_ff @(posedge clk16f or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= ST_IDLE;
      phase_q      <= 4'd0;
      settle_q     <= 4'd0;
      clk4f_q      <= 1'b1;
      clk2f_q      <= 1'b1;
      clkf_q       <= 1'b1;
      frame_strb_q <= 1'b0;
      clk_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      settle_q     <= settle_d;
      clk4f_q      <= clk4f_d;
      clk2f_q      <= clk2f_d;
      clkf_q       <= clkf_d;
      frame_strb_q <= frame_strb_d;
      clk_ready_q  <= clk_ready_d;
    end
  end

  assign clk4f      = clk4f_q;
  assign clk2f      = clk2f_q;
  assign clkf       = clkf_q;
  assign phase      = phase_q;
  assign frame_strb = frame_strb_q;
  assign clk_ready  = clk_ready_q;

endmodule
